tone_packetizer: RTL
====================

Name: tone_packetizer

Overview:
- Sits directly downstream of the frequency selector. Consumes its 80-bit tone stream: tuser = {index[6:0], k[13:0]}, tlast marks the end of a frame.
- Buffers each frame and emits it as a framed 128-bit AXI-Stream packet for the DMA: one header beat, then one beat per stored tone sample.
- Absorbs output backpressure, because the upstream stage does not honour tready. Overflow is counted and reported, never silent.

Parameters:
- FIFO_AW, 8, log2 of sample FIFO depth (256 entries of 87 bits).
- DESC_AW, 2, log2 of descriptor FIFO depth (4 pending frames).
- CNT_W, 9, width of per-frame sample count (must hold 0..2^FIFO_AW).

Ports:
- dev_clk  in  1  single clock for all logic.
- dev_rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  80  tone sample.
- s_axis_tuser  in  21  {index[6:0], k[13:0]}.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tlast  in  1  last sample of frame.
- s_axis_tready  out  1  advisory: high when a beat would be stored.
- m_axis_tdata  out  128  packet beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- drop_cnt  out  16  saturating count of dropped samples since reset.
- frame_cnt  out  32  number of frames closed since reset.

Behaviour:
- Reset: all FIFOs empty, FSM = IDLE, all counters 0. m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 while dev_rst is high. An async assert mid-packet aborts the packet immediately; no completion is attempted.
- s_axis_tready = !sample_full. Input beats are taken on tvalid regardless of tready.
- Store: on tvalid with sample FIFO not full, write {index, data}. Increment open-frame count. If this is the first stored beat of the frame, latch k = tuser[13:0].
- Drop: on tvalid with sample FIFO full, discard the beat. drop_cnt saturates at 16'hFFFF. Set the open frame's drop flag; the frame's count excludes the dropped beat.
- Close: a tlast beat closes the frame whether or not its sample was stored.
  - Normal close: push descriptor {k, count, drop flag, merged flag} and increment frame_cnt. Clear count and flags, same cycle.
  - If the descriptor FIFO is full at close, the frame stays open and later samples merge into it. Set the merged flag. The next tlast that finds space closes it.
- Store and close in the same cycle: the closing beat's sample is counted in the closing descriptor.
- Output FSM:
  - IDLE: when the descriptor FIFO is non-empty, go to HDR.
  - HDR: present the header. On tvalid&&tready, pop the descriptor. If count==0, assert tlast on the header and go to IDLE; otherwise go to PAY.
  - PAY: present the FIFO head (first-word-fall-through). Pop on each handshake. tlast on beat number count; then go to IDLE.
- Output must not change while tvalid=1 and tready=0.
- Header layout:
  - [127:112] 16'hF5E1.
  - [111:96] 0.
  - [95:64] frame sequence number, equal to frame_cnt value at close, starting at 0.
  - [63:50] k.
  - [49] merged flag. [48] drop flag.
  - [47:48-CNT_W] count, i.e. [47:39] at default CNT_W=9.
  - Remaining bits [38:0] at default: 0, except timestamp (see Optional Feature).
- Sample beat layout: [127:87] 0, [86:80] index, [79:0] data.
- Latency: input tlast to header tvalid is 2 cycles when IDLE and FIFOs hold no earlier frame. Zero-bubble header→payload and packet→packet at tready=1.
- Simultaneous write/read on a full sample FIFO: the read frees the slot in the next cycle only. The write in that cycle is dropped.

Optional Feature:
- TONE_PACKETIZER_TS_EN:
  - When defined: a free-running 32-bit cycle counter (reset 0, wraps) is captured at frame close and stored in the descriptor; the header carries it in [31:0].
  - When undefined: header [31:0] = 0 and no counter logic exists.

Test Plan:
- 4-beat frame, k=14'd37, indices 0..3, tready=1 → 5 beats: header with count=4, seq 0, k=37, flags 0; payload indices 0..3; tlast on beat 5; frame_cnt=1.
- Lone tlast beat into a frame with zero stored samples while the sample FIFO is full → 1-beat header packet, count=0, tlast=1, drop flag=1; drop_cnt+1.
- tready=0 for 400 cycles during 300 continuous input beats (frame ends at beat 300) → 256 stored, drop_cnt=44; header count=256, drop flag=1; data stable while stalled.
- Five 1-beat frames, tready held low → 4 descriptors queued. The 5th frame merges with the 6th. Releasing tready gives 5 packets, the 5th with merged=1 and count=2.
- Async dev_rst pulse mid-payload (beat 3 of 8) → tvalid low the same cycle; counters 0. The next frame emits seq 0.
- With TONE_PACKETIZER_TS_EN defined, two frames closing 100 cycles apart → header [31:0] values differ by exactly 100.

Source files
------------

// File: rtl/tone_packetizer.sv
// tone_packetizer: buffers frames of tone samples and re-emits each one as a
// 128-bit AXI-Stream packet made of a header beat followed by the stored samples.
// The upstream side ignores s_axis_tready, so beats that find the sample FIFO
// full are dropped and counted.
// Optional feature macro: TONE_PACKETIZER_TS_EN. When defined, a free-running
// cycle counter is captured at frame close and placed in header [31:0].
//
// Output handshake: a beat transfers on a clock edge where m_axis_tvalid and
// m_axis_tready are both high. Once valid is raised, tdata, tlast and valid
// stay unchanged until that transfer happens.
module tone_packetizer #(
    parameter int FIFO_AW = 8,
    parameter int DESC_AW = 2,
    parameter int CNT_W   = 9
) (
    input  logic         dev_clk,
    input  logic         dev_rst,
    input  logic [79:0]  s_axis_tdata,
    input  logic [20:0]  s_axis_tuser,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [15:0]  drop_cnt,
    output logic [31:0]  frame_cnt
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int DDEPTH = 1 << DESC_AW;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
    state_t state, state_nx;

    // Sample FIFO: {index, data}, first-word-fall-through read.
    logic [86:0]        s_mem [DEPTH];
    logic [FIFO_AW-1:0] s_wp, s_rp;
    logic [FIFO_AW:0]   s_num;
    logic               s_full, s_empty, s_pop;
    logic [86:0]        s_head;

    // Descriptor FIFO, one entry per closed frame.
    logic [13:0]        d_k    [DDEPTH];
    logic [CNT_W-1:0]   d_cnt  [DDEPTH];
    logic               d_drop [DDEPTH];
    logic               d_mrg  [DDEPTH];
    logic [31:0]        d_seq  [DDEPTH];
`ifdef TONE_PACKETIZER_TS_EN
    logic [31:0]        d_ts   [DDEPTH];
    logic [31:0]        ts_cnt;
`endif
    logic [DESC_AW-1:0] d_wp, d_rp;
    logic [DESC_AW:0]   d_num;
    logic               d_full, d_pop;

    // Open (not yet closed) frame state.
    logic [CNT_W-1:0]   open_cnt, close_cnt;
    logic [13:0]        open_k, close_k;
    logic               open_drop, open_mrg, close_drop;
    logic               in_store, in_drop, in_close;

    logic [CNT_W-1:0]   pay_left;
    logic               load_left;
    logic [127:0]       hdr;

    assign s_full  = s_num[FIFO_AW];
    assign s_empty = (s_num == '0);
    assign s_head  = s_mem[s_rp];
    assign d_full  = d_num[DESC_AW];

    assign s_axis_tready = !s_full && !dev_rst;

    // Fullness is taken from registered occupancy, so a read in the same cycle
    // does not make room for this cycle's write.
    assign in_store = s_axis_tvalid && !s_full;
    assign in_drop  = s_axis_tvalid && s_full;
    assign in_close = s_axis_tvalid && s_axis_tlast && !d_full;

    // The closing beat's own sample, if stored, belongs to the closing frame.
    assign close_cnt  = open_cnt + CNT_W'(in_store);
    assign close_k    = (in_store && open_cnt == '0) ? s_axis_tuser[13:0] : open_k;
    assign close_drop = open_drop | in_drop;

    // Sample storage write port (contents need no reset; occupancy guards reads).
    always_ff @(posedge dev_clk) begin
        if (in_store) s_mem[s_wp] <= {s_axis_tuser[20:14], s_axis_tdata};
    end

    // Descriptor storage write port.
    always_ff @(posedge dev_clk) begin
        if (in_close) begin
            d_k[d_wp]    <= close_k;
            d_cnt[d_wp]  <= close_cnt;
            d_drop[d_wp] <= close_drop;
            d_mrg[d_wp]  <= open_mrg;
            d_seq[d_wp]  <= frame_cnt;
`ifdef TONE_PACKETIZER_TS_EN
            d_ts[d_wp]   <= ts_cnt;
`endif
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            s_wp  <= '0;
            s_rp  <= '0;
            s_num <= '0;
            d_wp  <= '0;
            d_rp  <= '0;
            d_num <= '0;
        end else begin
            if (in_store) s_wp <= s_wp + FIFO_AW'(1);
            if (s_pop)    s_rp <= s_rp + FIFO_AW'(1);
            case ({in_store, s_pop})
                2'b10:   s_num <= s_num + (FIFO_AW+1)'(1);
                2'b01:   s_num <= s_num - (FIFO_AW+1)'(1);
                default: s_num <= s_num;
            endcase
            if (in_close) d_wp <= d_wp + DESC_AW'(1);
            if (d_pop)    d_rp <= d_rp + DESC_AW'(1);
            case ({in_close, d_pop})
                2'b10:   d_num <= d_num + (DESC_AW+1)'(1);
                2'b01:   d_num <= d_num - (DESC_AW+1)'(1);
                default: d_num <= d_num;
            endcase
        end
    end

    // Open-frame accumulation; a tlast that finds no descriptor slot keeps the
    // frame open and marks it merged.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            open_cnt  <= '0;
            open_k    <= '0;
            open_drop <= 1'b0;
            open_mrg  <= 1'b0;
        end else if (in_close) begin
            open_cnt  <= '0;
            open_k    <= '0;
            open_drop <= 1'b0;
            open_mrg  <= 1'b0;
        end else begin
            if (in_store) begin
                open_cnt <= close_cnt;
                open_k   <= close_k;
            end
            if (in_drop) open_drop <= 1'b1;
            if (s_axis_tvalid && s_axis_tlast) open_mrg <= 1'b1;
        end
    end

    // Status counters: saturating drop count and closed-frame count.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (in_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (in_close) frame_cnt <= frame_cnt + 32'd1;
        end
    end

`ifdef TONE_PACKETIZER_TS_EN
    // Free-running timestamp counter, wraps naturally.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) ts_cnt <= '0;
        else         ts_cnt <= ts_cnt + 32'd1;
    end
`endif

    // Header beat assembled from the descriptor at the FIFO head.
    always_comb begin
        hdr                 = '0;
        hdr[127:112]        = 16'hF5E1;
        hdr[95:64]          = d_seq[d_rp];
        hdr[63:50]          = d_k[d_rp];
        hdr[49]             = d_mrg[d_rp];
        hdr[48]             = d_drop[d_rp];
        hdr[47 -: CNT_W]    = d_cnt[d_rp];
`ifdef TONE_PACKETIZER_TS_EN
        hdr[31:0]           = d_ts[d_rp];
`endif
    end

    // Output FSM state register; reset aborts any packet in flight.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) state <= IDLE;
        else         state <= state_nx;
    end

    // Remaining payload beats of the packet being sent.
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst)        pay_left <= '0;
        else if (load_left) pay_left <= d_cnt[d_rp];
        else if (s_pop)     pay_left <= pay_left - CNT_W'(1);
    end

    // Output FSM next state and beat presentation; chains directly into the
    // next header when another descriptor is waiting, for zero-bubble packets.
    always_comb begin
        state_nx      = state;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        d_pop         = 1'b0;
        s_pop         = 1'b0;
        load_left     = 1'b0;
        case (state)
            IDLE: begin
                if (d_num != '0) state_nx = HDR;
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr;
                m_axis_tlast  = (d_cnt[d_rp] == '0);
                if (m_axis_tready) begin
                    d_pop = 1'b1;
                    if (d_cnt[d_rp] == '0) begin
                        state_nx = (d_num > (DESC_AW+1)'(1)) ? HDR : IDLE;
                    end else begin
                        load_left = 1'b1;
                        state_nx  = PAY;
                    end
                end
            end
            PAY: begin
                m_axis_tvalid = !s_empty;
                m_axis_tdata  = {41'h0, s_head};
                m_axis_tlast  = (pay_left == CNT_W'(1));
                if (m_axis_tvalid && m_axis_tready) begin
                    s_pop = 1'b1;
                    if (pay_left == CNT_W'(1)) state_nx = (d_num != '0) ? HDR : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
